// File: rtl/div_iter_param_if.sv
// Handshake bundle between the EX stage (master) and the iterative divider (slave).
interface div_iter_param_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               div_zero_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_zero_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_zero_o, busy_o
  );
endinterface

// File: rtl/div_iter_param.sv
// Iterative restoring divider retiring BPC quotient bits per cycle; signed/unsigned,
// returns {remainder, quotient} through a start/ready handshake with pipeline annul.
module div_iter_param #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  div_iter_param_if.slave  bus
);
  localparam int K  = WIDTH / BPC;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [2:0] {S_FREE, S_BYZERO, S_ON, S_FIX, S_END} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               sgn_q, neg_a, neg_b;
  logic [WIDTH-1:0]   dvs;   // divisor magnitude
  logic [WIDTH-1:0]   quo;   // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q, dz_q;

  logic [WIDTH-1:0]   mag_a, mag_b, rem_nx, quo_nx, q_fix, r_fix;
  logic [WIDTH:0]     part;

  assign mag_a = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign mag_b = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  assign q_fix = (sgn_q && (neg_a ^ neg_b)) ? -quo : quo;
  assign r_fix = (sgn_q && neg_a) ? -rem : rem;

  // NOTE: every variable gets a default first so this block can never infer a latch;
  // blocking assignments here chain the BPC steps into one combinational cycle.
  always_comb begin
    rem_nx = rem;
    quo_nx = quo;
    part   = '0;
    for (int i = 0; i < BPC; i++) begin
      part   = {rem_nx, quo_nx[WIDTH-1]};
      quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
      if (part >= {1'b0, dvs}) begin
        part      = part - {1'b0, dvs};
        quo_nx[0] = 1'b1;
      end
      rem_nx = part[WIDTH-1:0];
    end
  end

  // NOTE: state and outputs use non-blocking assignments; the datapath registers are
  // left out of reset because they are always loaded at acceptance before being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          result_q <= '0;
          ready_q  <= 1'b0;
          dz_q     <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            sgn_q <= bus.signed_div_i;
            neg_a <= bus.signed_div_i && bus.opdata1_i[WIDTH-1];
            neg_b <= bus.signed_div_i && bus.opdata2_i[WIDTH-1];
            cnt   <= '0;
            if (bus.opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              dvs   <= mag_b;
              quo   <= mag_a;
              rem   <= '0;
            end
          end
        end
        // The zero-divisor result is presented on the second edge after acceptance.
        S_BYZERO: begin
          if (bus.annul_i) begin
            state <= S_FREE;
          end else if (cnt == CW'(1)) begin
            state    <= S_END;
            result_q <= '0;
            ready_q  <= 1'b1;
            dz_q     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ON: begin
          if (bus.annul_i) begin
            state <= S_FREE;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(K - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.annul_i) begin
            state <= S_FREE;
          end else begin
            state    <= S_END;
            result_q <= {r_fix, q_fix};
            ready_q  <= 1'b1;
            dz_q     <= 1'b0;
          end
        end
        S_END: begin
          if (!bus.start_i) begin
            state    <= S_FREE;
            result_q <= '0;
            ready_q  <= 1'b0;
            dz_q     <= 1'b0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.div_zero_o = dz_q;
  assign bus.busy_o     = (state != S_FREE);
endmodule
